// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;
   localparam int SUB_WIDTH = 8;
   localparam int SUB_IDX_W = 3;
   typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/serial_subtractor8_fs.sv
// full_subtractor1: one-bit full subtractor cell, purely combinational.
module full_subtractor1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor8.sv
// serial_subtractor8: LSB-first bit-serial a - b with start/busy/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor8
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic [WIDTH-1:0] borrow,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
   state_t state;
   logic [IW-1:0] idx;
   logic [WIDTH-1:0] a_r, b_r;
   logic bin, d, bo;
   // The single cell is time-shared; the previous stage's borrow feeds back from the register.
   assign bin = (idx == '0) ? 1'b0 : borrow[idx - IW'(1)];
   full_subtractor1 u_fs (
      .a   (a_r[idx]),
      .b   (b_r[idx]),
      .bin (bin),
      .d   (d),
      .bout(bo)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         diff   <= '0;
         borrow <= '0;
         bout   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (state == IDLE) begin
         done <= 1'b0;
         if (start) begin
            a_r    <= a;
            b_r    <= b;
            diff   <= '0;
            borrow <= '0;
            bout   <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
         end
      end else begin
         diff[idx]   <= d;
         borrow[idx] <= bo;
         idx         <= idx + IW'(1);
         if (idx == LAST) begin
            bout  <= bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d != a_r[WIDTH-1]);
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor8.sv
// tb_serial_subtractor8: randomized and directed checks against an arithmetic reference model.
module tb_serial_subtractor8;
   logic clk = 0, rst = 1, start = 0, busy, done, bout;
   logic [7:0] a = 0, b = 0, diff, borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic ovf;
`endif
   int n_checks = 0, n_fail = 0;

   serial_subtractor8 dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow),
`ifdef SERIAL_SUB_OVF_EN
      .ovf(ovf),
`endif
      .bout(bout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Borrow out of stage i means the low i+1 bits of a are smaller than those of b.
   function automatic logic [7:0] m_borrow(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = (int'(x) % (1 << (i + 1))) < (int'(y) % (1 << (i + 1)));
      return r;
   endfunction

   function automatic logic [7:0] m_diff(input logic [7:0] x, input logic [7:0] y);
      return 8'((int'(x) - int'(y) + 256) % 256);
   endfunction

   function automatic logic m_ovf(input logic [7:0] x, input logic [7:0] y);
      int s;
      s = int'($signed(x)) - int'($signed(y));
      return (s < -128) || (s > 127);
   endfunction

   task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y);
      check({tag, "_diff"}, diff, m_diff(x, y));
      check({tag, "_borrow"}, borrow, m_borrow(x, y));
      check({tag, "_bout"}, bout, x < y);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ovf, m_ovf(x, y));
`endif
   endtask

   // Called from IDLE, #1 after an edge; operands are scrambled while busy.
   task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
      int n, bc;
      logic seen;
      a = x; b = y; start = 1;
      @(posedge clk); #1 start = 0;
      check({tag, "_accept_busy"}, busy, 1);
      bc = busy ? 1 : 0;
      seen = 0; n = 0;
      while (!seen && n < 20) begin
         a = 8'($urandom); b = 8'($urandom);
         @(posedge clk); #1 n++;
         if (done) seen = 1;
         else if (busy) bc++;
      end
      check({tag, "_latency"}, n, 8);
      check({tag, "_busy_cycles"}, bc, 8);
      check_result(tag, x, y);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check_result({tag, "_hold"}, x, y);
   endtask

   initial begin
      int n, nd, last;
      logic seen;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_bout", bout, 0);
      rst = 0;
      @(posedge clk); #1;
      check("idle_hold_done", done, 0);

      run_op("d05_03", 8'h05, 8'h03);
      run_op("d00_01", 8'h00, 8'h01);
      run_op("d80_01", 8'h80, 8'h01);
      run_op("d00_00", 8'h00, 8'h00);
      run_op("dff_ff", 8'hFF, 8'hFF);
      run_op("d00_ff", 8'h00, 8'hFF);
      run_op("dff_00", 8'hFF, 8'h00);
      run_op("d7f_80", 8'h7F, 8'h80);

      // Start while busy must be ignored.
      a = 8'h10; b = 8'h01; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (2) @(posedge clk);
      #1 a = 8'hFF; b = 8'hFF; start = 1;
      @(posedge clk); #1 start = 0;
      n = 3; seen = 0;
      while (!seen && n < 20) begin
         @(posedge clk); #1 n++;
         seen = done;
      end
      check("busy_ign_latency", n, 8);
      check_result("busy_ign", 8'h10, 8'h01);
      @(posedge clk); #1;
      check("busy_ign_no_restart", busy, 0);

      // Start held high: back-to-back runs every 9 cycles with no idle gap.
      a = 8'h22; b = 8'h11; start = 1;
      @(posedge clk); #1;
      nd = 0; last = 0;
      for (int i = 1; i <= 26; i++) begin
         @(posedge clk); #1;
         check("b2b_no_gap", busy | done, 1);
         if (done) begin
            check("b2b_period", i - last, (nd == 0) ? 8 : 9);
            check_result("b2b", 8'h22, 8'h11);
            last = i; nd++;
         end
      end
      check("b2b_count", nd, 3);
      start = 0;
      @(posedge clk); #1;
      check("b2b_stop_busy", busy, 0);
      check("b2b_stop_done", done, 0);

      // Reset at the 4th CALC edge aborts without a done pulse.
      a = 8'h3C; b = 8'h5A; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow, 0);
      check("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_ovf", ovf, 0);
`endif
      nd = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) nd++;
      end
      check("abort_quiet", nd, 0);
      run_op("d3c_5a", 8'h3C, 8'h5A);

      for (int i = 0; i < 16; i++) run_op("rand", 8'($urandom), 8'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
